// File: rtl/ext_irq_ctrl_if.sv
// rtl/ext_irq_ctrl_if.sv - iomem bus bundle between the picosoc core and ext_irq_ctrl
//
// Signals:
//   iomem_valid  master->slave  bus request
//   iomem_ready  slave->master  one-cycle acknowledge
//   iomem_wstrb  master->slave  byte write strobes (0 = read)
//   iomem_addr   master->slave  byte address
//   iomem_wdata  master->slave  write data
//   iomem_rdata  slave->master  read data, valid with iomem_ready
interface ext_irq_ctrl_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata
    );

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata
    );
endinterface

// File: rtl/ext_irq_ctrl.sv
// rtl/ext_irq_ctrl.sv - switch-input interrupt conditioner with iomem register view
//
// Ports:
//   clk      system clock
//   resetn   synchronous active-low reset
//   irq_in   raw asynchronous switch inputs (NUM_IRQ)
//   irq_out  interrupt lines to soc irq_5.. (bit 0 = irq_5)
//   bus      iomem slave (valid/ready/wstrb/addr/wdata/rdata)
//
// Registers (addr[3:2]): 0 STATUS (RO stable), 1 ENABLE, 2 EDGE (0 rise, 1 fall),
// 3 PENDING (write 1 to clear).
//
// Build option: EXT_IRQ_PULSE_MODE_EN makes irq_out a one-cycle pulse per enabled
// event instead of the level pending & enable.
module ext_irq_ctrl #(
    parameter int          NUM_IRQ         = 3,
    parameter int          DEBOUNCE_CYCLES = 65536,
    parameter logic [7:0]  BASE_ADDR       = 8'h04
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic [NUM_IRQ-1:0] irq_out,
    ext_irq_ctrl_if.slave      bus
);
    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_IRQ-1:0]         sync1;
    logic [NUM_IRQ-1:0]         sync;
    logic [NUM_IRQ-1:0]         stable;
    logic [NUM_IRQ-1:0]         stable_nxt;
    logic [NUM_IRQ-1:0]         enable;
    logic [NUM_IRQ-1:0]         edge_sel;
    logic [NUM_IRQ-1:0]         pending;
    logic [NUM_IRQ-1:0]         evt;
    logic [NUM_IRQ-1:0][CW-1:0] count;
    logic [NUM_IRQ-1:0][CW-1:0] count_nxt;
    logic [CW-1:0]              startup_cnt;
    logic                       startup_done;

    logic                       sel;
    logic                       wr;
    logic [1:0]                 reg_idx;
    logic [NUM_IRQ-1:0]         wdata_n;
    logic [31:0]                rd_val;
    logic                       unused_bits;

    // Debounce: a channel must disagree with stable for DEBOUNCE_CYCLES
    // consecutive cycles before stable follows it. During the startup window
    // stable simply tracks sync so levels present at reset never look like edges.
    always_comb begin
        stable_nxt = stable;
        count_nxt  = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (!startup_done) begin
                stable_nxt[i] = sync[i];
            end else if (sync[i] != stable[i]) begin
                if (count[i] == CNT_MAX) begin
                    stable_nxt[i] = sync[i];
                end else begin
                    count_nxt[i] = count[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        evt = '0;
        if (startup_done) begin
            evt = ((stable_nxt & ~stable) & ~edge_sel) |
                  ((~stable_nxt & stable) & edge_sel);
        end
    end

    // A request is taken only while ready is low, so back-to-back requests
    // are acknowledged on alternate cycles.
    assign sel     = bus.iomem_valid && !bus.iomem_ready &&
                     (bus.iomem_addr[31:24] == BASE_ADDR);
    assign wr      = sel && bus.iomem_wstrb[0];
    assign reg_idx = bus.iomem_addr[3:2];
    assign wdata_n = bus.iomem_wdata[NUM_IRQ-1:0];

    always_comb begin
        rd_val = '0;
        case (reg_idx)
            2'd0:    rd_val[NUM_IRQ-1:0] = stable;
            2'd1:    rd_val[NUM_IRQ-1:0] = enable;
            2'd2:    rd_val[NUM_IRQ-1:0] = edge_sel;
            default: rd_val[NUM_IRQ-1:0] = pending;
        endcase
    end

    assign unused_bits = ^{bus.iomem_addr[23:4], bus.iomem_addr[1:0],
                           bus.iomem_wdata, bus.iomem_wstrb[3:1]};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1           <= '0;
            sync            <= '0;
            stable          <= '0;
            count           <= '0;
            startup_cnt     <= '0;
            startup_done    <= 1'b0;
            enable          <= '0;
            edge_sel        <= '0;
            pending         <= '0;
            irq_out         <= '0;
            bus.iomem_ready <= 1'b0;
            bus.iomem_rdata <= '0;
        end else begin
            sync1  <= irq_in;
            sync   <= sync1;
            stable <= stable_nxt;
            count  <= count_nxt;

            if (!startup_done) begin
                if (startup_cnt == CNT_MAX) begin
                    startup_done <= 1'b1;
                end else begin
                    startup_cnt <= startup_cnt + CW'(1);
                end
            end

            bus.iomem_ready <= sel;
            bus.iomem_rdata <= sel ? rd_val : 32'd0;

            if (wr && reg_idx == 2'd1) begin
                enable <= wdata_n;
            end
            if (wr && reg_idx == 2'd2) begin
                edge_sel <= wdata_n;
            end

            // Event set is applied after the clear so it wins on a collision.
            if (wr && reg_idx == 2'd3) begin
                pending <= (pending & ~wdata_n) | evt;
            end else begin
                pending <= pending | evt;
            end

`ifdef EXT_IRQ_PULSE_MODE_EN
            irq_out <= evt & enable;
`else
            irq_out <= pending & enable;
`endif
        end
    end
endmodule
